// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cordic_pkg                                                      |
// | Purpose  : Shared constants and octant-to-flag decode for the CORDIC front. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cordic_pkg;

    localparam int PI_4_Q15        = 25736;
    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_PHASE_W = 16;

    // Returns {swap_xy, neg_sin, neg_cos} for the octant of the sampled phase.
    function automatic logic [2:0] octant_flags(input logic [2:0] oct);
        logic [2:0] flags;
        case (oct)
            3'd0:    flags = 3'b000;
            3'd1:    flags = 3'b100;
            3'd2:    flags = 3'b101;
            3'd3:    flags = 3'b001;
            3'd4:    flags = 3'b011;
            3'd5:    flags = 3'b111;
            3'd6:    flags = 3'b110;
            default: flags = 3'b010;
        endcase
        return flags;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_phase_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cordic_phase_gen_if                                             |
// | Purpose  : Control inputs and angle/flag output handshake of the phase gen. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cordic_phase_gen_if
    import cordic_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int WIDTH   = DEFAULT_WIDTH
);
    logic                     en;
    logic [PHASE_W-1:0]       freq_word;
    logic                     phase_ld;
    logic [PHASE_W-1:0]       phase_init;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH-1:0]  angle;
    logic [2:0]               octant;
    logic                     swap_xy;
    logic                     neg_sin;
    logic                     neg_cos;

    modport master (
        input  en, freq_word, phase_ld, phase_init, out_ready,
        output out_valid, angle, octant, swap_xy, neg_sin, neg_cos
    );

    modport slave (
        output en, freq_word, phase_ld, phase_init, out_ready,
        input  out_valid, angle, octant, swap_xy, neg_sin, neg_cos
    );
endinterface
`default_nettype wire

// File: rtl/phase_dither_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phase_dither_lfsr                                               |
// | Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying phase dither. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`ifdef PHASE_DITHER_EN
module phase_dither_lfsr (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_adv,
    output logic [2:0]      o_dither
);
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_SEED;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign o_dither = r_lfsr[2:0];
endmodule
`endif
`default_nettype wire

// File: rtl/cordic_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cordic_phase_gen                                                |
// | Purpose  : Phase accumulator with octant folding into a [0, pi/4] angle    |
// |            plus swap/negate flags; optional dither via PHASE_DITHER_EN.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cordic_phase_gen_if.master  bus
);
    localparam int c_RES_W  = PHASE_W - 3;
    localparam int c_FOLD_W = PHASE_W - 2;
    localparam int c_PROD_W = c_FOLD_W + 15;
    localparam logic [c_FOLD_W-1:0] c_RES_SPAN = {1'b1, {c_RES_W{1'b0}}};

    logic [PHASE_W-1:0]       r_acc;
    logic [PHASE_W-1:0]       w_phase;
    logic                     w_stall;
    logic                     w_sample;
    logic [2:0]               w_oct;
    logic [c_RES_W-1:0]       w_res;
    logic [c_FOLD_W-1:0]      w_fold;
    logic [c_PROD_W-1:0]      w_prod;

    logic                     r_s1_valid;
    logic [2:0]               r_s1_oct;
    logic [c_FOLD_W-1:0]      r_s1_res;

    logic                     r_out_valid;
    logic signed [WIDTH-1:0]  r_angle;
    logic [2:0]               r_octant;
    logic                     r_swap;
    logic                     r_nsin;
    logic                     r_ncos;

    assign w_stall  = r_out_valid && !bus.out_ready;
    assign w_sample = bus.en && !bus.phase_ld && !w_stall;

`ifdef PHASE_DITHER_EN
    logic [2:0] w_dither;

    phase_dither_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_adv    (w_sample),
        .o_dither (w_dither)
    );

    // Dither perturbs only the sampled phase; the accumulator stays exact.
    assign w_phase = r_acc + PHASE_W'(w_dither);
`else
    assign w_phase = r_acc;
`endif

    assign w_oct  = w_phase[PHASE_W-1 -: 3];
    assign w_res  = w_phase[c_RES_W-1:0];
    assign w_fold = w_oct[0] ? (c_RES_SPAN - {1'b0, w_res}) : {1'b0, w_res};
    assign w_prod = c_PROD_W'(r_s1_res) * c_PROD_W'(PI_4_Q15);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_oct    <= '0;
            r_s1_res    <= '0;
            r_out_valid <= 1'b0;
            r_angle     <= '0;
            r_octant    <= '0;
            r_swap      <= 1'b0;
            r_nsin      <= 1'b0;
            r_ncos      <= 1'b0;
        end else begin
            if (bus.phase_ld) begin
                r_acc <= bus.phase_init;
            end else if (w_sample) begin
                r_acc <= r_acc + bus.freq_word;
            end

            if (w_sample) begin
                r_s1_oct <= w_oct;
                r_s1_res <= w_fold;
            end

            // Stage 2 is free or handing off whenever not stalled.
            if (!w_stall) begin
                r_s1_valid  <= w_sample;
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_angle                    <= WIDTH'(w_prod >> c_RES_W);
                    r_octant                   <= r_s1_oct;
                    {r_swap, r_nsin, r_ncos}   <= octant_flags(r_s1_oct);
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.angle     = r_angle;
    assign bus.octant    = r_octant;
    assign bus.swap_xy   = r_swap;
    assign bus.neg_sin   = r_nsin;
    assign bus.neg_cos   = r_ncos;
endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cordic_phase_gen                                             |
// | Purpose  : Self-checking bench: vector table, directed corners, random     |
// |            streams scored against an arithmetic reference model.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cordic_phase_gen;
    localparam int PW   = 16;
    localparam int W    = 16;
    localparam int SPAN = 1 << (PW - 3);

    typedef struct {
        logic [15:0] phase;
        int          angle;
        int          oct;
        logic [2:0]  flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] flag_tab [8];
    vec_t vecs [13];

    always #5 clk = ~clk;

    cordic_phase_gen_if #(.PHASE_W(PW), .WIDTH(W)) bus ();

    cordic_phase_gen #(.PHASE_W(PW), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Phase -> (angle, octant, flags) from the folding rules, in plain integers.
    function automatic void ref_out(input int unsigned ph, output int ang,
                                    output int oct, output int fl);
        int unsigned p;
        int unsigned r;
        p   = ph % (1 << PW);
        oct = int'(p / SPAN);
        r   = p % SPAN;
        if (oct % 2 == 1) r = SPAN - r;
        ang = int'((longint'(r) * 25736) / SPAN);
        fl  = int'(flag_tab[oct]);
    endfunction

    task automatic check_pending(input string name, input int unsigned ph);
        int a, o, f;
        ref_out(ph, a, o, f);
        chk({name, ".angle"},  int'(bus.angle), a);
        chk({name, ".octant"}, int'(bus.octant), o);
        chk({name, ".flags"},  int'({bus.swap_xy, bus.neg_sin, bus.neg_cos}), f);
    endtask

    task automatic check_outs(input string name, input int a, input int o, input int f);
        chk({name, ".angle"},  int'(bus.angle), a);
        chk({name, ".octant"}, int'(bus.octant), o);
        chk({name, ".flags"},  int'({bus.swap_xy, bus.neg_sin, bus.neg_cos}), f);
    endtask

    // Load base, then run ncyc cycles; every delivered item k must be base+k*freq.
    task automatic stream(input string name, input int unsigned base, input int unsigned freq,
                          input int ncyc, input int en_pct, input int rdy_pct,
                          input int stall_at, output int delivered);
        int k;
        k = 0;
        bus.phase_ld   = 1'b1;
        bus.phase_init = base[15:0];
        bus.freq_word  = freq[15:0];
        bus.en         = 1'b0;
        step();
        bus.phase_ld = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            bus.en = ($urandom_range(99) < en_pct);
            if (stall_at >= 0 && c >= stall_at && c < stall_at + 5) begin
                bus.out_ready = 1'b0;
                if (c > stall_at) chk({name, ".stall_valid"}, int'(bus.out_valid), 1);
            end else begin
                bus.out_ready = ($urandom_range(99) < rdy_pct);
            end
            if (bus.out_valid) begin
                check_pending(name, base + k * freq);
                if (bus.out_ready) k++;
            end
            step();
        end
        bus.en        = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) begin
                check_pending(name, base + k * freq);
                k++;
            end
            step();
        end
        chk({name, ".drained"}, int'(bus.out_valid), 0);
        delivered = k;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        flag_tab = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011, 3'b111, 3'b110, 3'b010};
        vecs[0]  = '{16'h0000,     0, 0, 3'b000};
        vecs[1]  = '{16'h2000, 25736, 1, 3'b100};
        vecs[2]  = '{16'h1555, 17156, 0, 3'b000};
        vecs[3]  = '{16'hF000, 12868, 7, 3'b010};
        vecs[4]  = '{16'h4000,     0, 2, 3'b101};
        vecs[5]  = '{16'h6000, 25736, 3, 3'b001};
        vecs[6]  = '{16'h8000,     0, 4, 3'b011};
        vecs[7]  = '{16'hA000, 25736, 5, 3'b111};
        vecs[8]  = '{16'hC000,     0, 6, 3'b110};
        vecs[9]  = '{16'hE000, 25736, 7, 3'b010};
        vecs[10] = '{16'h1FFF, 25732, 0, 3'b000};
        vecs[11] = '{16'h2001, 25732, 1, 3'b100};
        vecs[12] = '{16'h0001,     3, 0, 3'b000};

        bus.en = 1'b0; bus.phase_ld = 1'b0; bus.phase_init = '0;
        bus.freq_word = '0; bus.out_ready = 1'b1;
        step(); step();
        chk("reset.valid", int'(bus.out_valid), 0);
        check_outs("reset", 0, 0, 0);
        rst = 1'b0;

        // Single sample per vector, with the two-cycle latency checked.
        for (int i = 0; i < 13; i++) begin
            bus.phase_ld = 1'b1; bus.phase_init = vecs[i].phase; bus.en = 1'b0;
            step();
            bus.phase_ld = 1'b0; bus.en = 1'b1;
            step();
            bus.en = 1'b0;
            chk("vec.lat1_valid", int'(bus.out_valid), 0);
            step();
            chk("vec.lat2_valid", int'(bus.out_valid), 1);
            check_outs("vec", vecs[i].angle, vecs[i].oct, int'(vecs[i].flags));
            step();
            chk("vec.after_valid", int'(bus.out_valid), 0);
        end

        stream("octsweep", 32'h0000, 32'h2000, 9, 100, 100, -1, n);
        chk("octsweep.count", n, 9);
        stream("wrap", 32'hF000, 32'h1000, 2, 100, 100, -1, n);
        chk("wrap.count", n, 2);
        stream("stall5", 32'h0000, 32'h0800, 20, 100, 100, 4, n);
        chk("stall5.count", n, 15);

        // Load and enable together: no sample on the load cycle.
        bus.phase_ld = 1'b1; bus.en = 1'b1; bus.phase_init = 16'h1555; bus.freq_word = 16'h2000;
        step();
        chk("ldén.valid0", int'(bus.out_valid), 0);
        bus.phase_ld = 1'b0;
        step();
        chk("lden.valid1", int'(bus.out_valid), 0);
        bus.en = 1'b0;
        step();
        chk("lden.valid2", int'(bus.out_valid), 1);
        check_outs("lden", 17156, 0, 0);
        step();
        chk("lden.valid3", int'(bus.out_valid), 0);

        // Reset during a stall with a full pipeline.
        bus.phase_ld = 1'b1; bus.phase_init = 16'h2000; bus.freq_word = 16'h1000;
        bus.out_ready = 1'b0;
        step();
        bus.phase_ld = 1'b0; bus.en = 1'b1;
        step(); step(); step();
        bus.en = 1'b0;
        chk("rststall.pre_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rststall.valid", int'(bus.out_valid), 0);
        check_outs("rststall", 0, 0, 0);
        bus.out_ready = 1'b1; bus.en = 1'b1;
        step(); step();
        bus.en = 1'b0;
        chk("rststall.item0_valid", int'(bus.out_valid), 1);
        check_outs("rststall.item0", 0, 0, 0);
        step();
        check_outs("rststall.item1", 12868, 0, 0);
        step();
        chk("rststall.end_valid", int'(bus.out_valid), 0);

        for (int s = 0; s < 6; s++) begin
            stream("rand", $urandom & 32'hFFFF, $urandom & 32'hFFFF, 200,
                   50 + int'($urandom_range(50)), 30 + int'($urandom_range(70)), -1, n);
            chk("rand.some_delivered", int'(n > 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
